// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared TDM framing constants and state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;
endpackage
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_ctr
// Description : 3-bit TDM slot counter with enable, load-to-1 and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_clr,
    output logic [SLOT_W-1:0] o_slot
);

    logic [SLOT_W-1:0] r_slot;

    // Clear wins over load; both only act on an enabled beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_slot <= '0;
            end else if (i_load) begin
                r_slot <= SLOT_W'(1);
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
            end
        end
    end

    assign o_slot = r_slot;

endmodule
`default_nettype wire

// File: rtl/demux1x8_tdm.sv
`default_nettype none
// ============================================================================
// Module      : demux1x8_tdm
// Description : 1:8 TDM serial-to-parallel demux with frame lock and flywheel.
// Revision    : 1.0 - initial release
// ============================================================================
module demux1x8_tdm
    import tdm_pkg::*;
#(
    parameter int MISS_LIMIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NUM_SLOTS-1:0] out,
    output logic                 out_valid,
    output logic                 locked,
    output logic                 sync_err
);

    localparam logic [1:0] c_MISS_LIMIT = 2'(MISS_LIMIT);

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [SLOT_W-1:0]    w_slot;
    logic [1:0]           r_miss;
    logic [NUM_SLOTS-2:0] r_shadow;
    logic [NUM_SLOTS-1:0] r_out;
    logic                 r_out_valid;
    logic                 r_sync_err;

    logic w_slot0;
    logic w_can_fly;
    logic w_ld;
    logic w_clr;
    logic w_inc;
    logic w_deliver;
    logic w_err;
    logic w_miss_clr;
    logic w_miss_inc;

    assign w_slot0   = (w_slot == '0);
    assign w_can_fly = (r_miss < c_MISS_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_state_nxt = LOCK;
                    end
                end
                default: begin
                    if (!frame_sync && w_slot0 && !w_can_fly) begin
                        w_state_nxt = HUNT;
                    end
                end
            endcase
        end
    end

    // Per-beat action decode; registered below so outputs have no input path.
    always_comb begin
        w_ld       = 1'b0;
        w_clr      = 1'b0;
        w_inc      = 1'b0;
        w_deliver  = 1'b0;
        w_err      = 1'b0;
        w_miss_clr = 1'b0;
        w_miss_inc = 1'b0;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_ld       = 1'b1;
                        w_miss_clr = 1'b1;
                    end
                end
                default: begin
                    if (frame_sync) begin
                        w_ld       = 1'b1;
                        w_err      = !w_slot0;
                        w_miss_clr = w_slot0;
                    end else if (!w_slot0) begin
                        w_inc      = 1'b1;
                        w_deliver  = (w_slot == SLOT_W'(NUM_SLOTS - 1));
                    end else begin
                        w_err = 1'b1;
                        if (w_can_fly) begin
                            w_ld       = 1'b1;
                            w_miss_inc = 1'b1;
                        end else begin
                            w_clr      = 1'b1;
                            w_miss_clr = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    tdm_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_ld | w_clr | w_inc),
        .i_load (w_ld),
        .i_clr  (w_clr),
        .o_slot (w_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss <= '0;
        end else if (w_miss_clr) begin
            r_miss <= '0;
        end else if (w_miss_inc) begin
            r_miss <= r_miss + 2'd1;
        end
    end

    // Slot 7 is never stored: it goes straight into the output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else begin
            if (w_ld) begin
                r_shadow[0] <= din;
            end
            if (w_inc) begin
                for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                    if (w_slot == SLOT_W'(k)) begin
                        r_shadow[k] <= din;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            if (w_deliver) begin
                r_out <= {din, r_shadow};
            end
            r_out_valid <= w_deliver;
            r_sync_err  <= w_err;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign sync_err  = r_sync_err;
    assign locked    = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_demux1x8_tdm.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux1x8_tdm
// Description : Self-checking bench for demux1x8_tdm (MISS_LIMIT = 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1x8_tdm;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] out;
    logic       out_valid;
    logic       locked;
    logic       sync_err;

    int total;
    int bad;

    typedef struct {
        logic       v;
        logic       fs;
        logic       d;
        logic [7:0] eo;
        logic       eov;
        logic       elk;
        logic       eerr;
    } vec_t;

    vec_t tv[$];

    demux1x8_tdm #(.MISS_LIMIT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out        (out),
        .out_valid  (out_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fs, input logic d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic v, input logic fs, input logic d,
                                input logic [7:0] eo, input logic eov,
                                input logic elk, input logic eerr);
        vec_t e;
        e.v = v; e.fs = fs; e.d = d; e.eo = eo; e.eov = eov; e.elk = elk; e.eerr = eerr;
        tv.push_back(e);
    endfunction

    // One locked frame; gap idle beats (with junk sync/data) inserted before slot 4.
    function automatic void add_frame(input logic [7:0] f, input logic fs0, input logic err0,
                                      input int gap, input logic [7:0] eprev);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                for (int g = 0; g < gap; g++) add(1'b0, 1'b1, 1'b1, eprev, 1'b0, 1'b1, 1'b0);
            end
            add(1'b1, (k == 0) ? fs0 : 1'b0, f[k], (k == 7) ? f : eprev,
                (k == 7), 1'b1, (k == 0) ? err0 : 1'b0);
        end
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] fr;
    logic [7:0] b81;
    logic [7:0] b55;
    logic [7:0] b0f;
    int         delivered;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;

        add_frame(8'h4D, 1'b1, 1'b0, 0, 8'h00);
        add_frame(8'hA5, 1'b1, 1'b0, 3, 8'h4D);
        add_frame(8'h3C, 1'b1, 1'b0, 0, 8'hA5);
        b0f = 8'h0F;
        for (int k = 0; k < 4; k++) add(1'b1, k == 0, b0f[k], 8'h3C, 1'b0, 1'b1, 1'b0);
        add_frame(8'hFF, 1'b1, 1'b1, 0, 8'h3C);
        add_frame(8'h96, 1'b0, 1'b1, 0, 8'hFF);
        add_frame(8'h5A, 1'b1, 1'b0, 0, 8'h96);
        add_frame(8'h69, 1'b0, 1'b1, 0, 8'h5A);
        b55 = 8'h55;
        for (int k = 0; k < 8; k++) add(1'b1, 1'b0, b55[k], 8'h69, 1'b0, 1'b0, k == 0);
        for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 1'b1, 8'h69, 1'b0, 1'b0, 1'b0);
        add_frame(8'hC3, 1'b1, 1'b0, 0, 8'h69);

        #12;
        chk("reset out", out, 8'h00);
        chk("reset out_valid", {7'b0, out_valid}, 8'h00);
        chk("reset locked", {7'b0, locked}, 8'h00);
        chk("reset sync_err", {7'b0, sync_err}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].v, tv[i].fs, tv[i].d);
            chk($sformatf("vec%0d out", i), out, tv[i].eo);
            chk($sformatf("vec%0d out_valid", i), {7'b0, out_valid}, {7'b0, tv[i].eov});
            chk($sformatf("vec%0d locked", i), {7'b0, locked}, {7'b0, tv[i].elk});
            chk($sformatf("vec%0d sync_err", i), {7'b0, sync_err}, {7'b0, tv[i].eerr});
        end

        // Async reset between edges, partway through a frame.
        fr = 8'h5A;
        for (int k = 0; k < 4; k++) drive(1'b1, k == 0, fr[k]);
        #2 rst = 1'b1;
        #1;
        chk("async rst out", out, 8'h00);
        chk("async rst locked", {7'b0, locked}, 8'h00);
        chk("async rst out_valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        b81 = 8'h81;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k == 0, b81[k]);
            chk($sformatf("post-rst ov%0d", k), {7'b0, out_valid}, {7'b0, k == 7});
            chk($sformatf("post-rst lk%0d", k), {7'b0, locked}, 8'h01);
            if (k < 7) chk($sformatf("post-rst hold%0d", k), out, 8'h00);
        end
        chk("post-rst out", out, 8'h81);

        // Random soak: transmit order slot k carries bit k, slot 0 flagged.
        delivered = 0;
        for (int f = 0; f < 1000; f++) begin
            fr = 8'($urandom_range(0, 255));
            exp_q.push_back(fr);
            for (int k = 0; k < 8; k++) begin
                while ($urandom_range(0, 3) == 0) begin
                    drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    chk("soak gap ov", {7'b0, out_valid}, 8'h00);
                    chk("soak gap err", {7'b0, sync_err}, 8'h00);
                end
                drive(1'b1, k == 0, fr[k]);
                chk("soak err", {7'b0, sync_err}, 8'h00);
                chk("soak ov", {7'b0, out_valid}, {7'b0, k == 7});
                if (out_valid) begin
                    delivered++;
                    if (exp_q.size() == 0) begin
                        chk("soak unexpected frame", out, 8'hXX);
                    end else begin
                        chk($sformatf("soak frame%0d", f), out, exp_q.pop_front());
                    end
                end
            end
        end
        chk("soak count lo", 8'(delivered), 8'(1000));
        chk("soak count hi", 8'(delivered >> 8), 8'(1000 >> 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
